// File: rtl/e203_exu_wbck_sched_if.sv
`default_nettype none
// ============================================================================
// Module   : e203_exu_wbck_sched_if
// Brief    : Bundles the dispatch, per-unit result and long-pipe writeback
//            handshakes of the writeback scheduler, plus its dependency
//            check and status signals.
// Revision : 1.0 - initial release
// ============================================================================
interface e203_exu_wbck_sched_if #(
  parameter int XLEN    = 32,
  parameter int RFIDX_W = 5
);
  // Dispatch of a long-pipe instruction into the tracking buffer
  logic               disp_i_valid;
  logic               disp_i_ready;
  logic               disp_i_unit;
  logic               disp_i_rdwen;
  logic [RFIDX_W-1:0] disp_i_rdidx;

  // LSU result
  logic               lsu_wbck_i_valid;
  logic               lsu_wbck_i_ready;
  logic [XLEN-1:0]    lsu_wbck_i_wdat;

  // MULDIV result
  logic               mdv_wbck_i_valid;
  logic               mdv_wbck_i_ready;
  logic [XLEN-1:0]    mdv_wbck_i_wdat;

  // Writeback towards the arbiter
  logic               longp_wbck_o_valid;
  logic               longp_wbck_o_ready;
  logic [XLEN-1:0]    longp_wbck_o_wdat;
  logic [RFIDX_W-1:0] longp_wbck_o_rdidx;

  // RAW dependency check from the dispatch stage
  logic               chk_rs1en;
  logic               chk_rs2en;
  logic               chk_rden;
  logic [RFIDX_W-1:0] chk_rs1idx;
  logic [RFIDX_W-1:0] chk_rs2idx;
  logic [RFIDX_W-1:0] chk_rdidx;
  logic               dep_o;
  logic               empty_o;

  // Scheduler side
  modport slave (
    input  disp_i_valid, disp_i_unit, disp_i_rdwen, disp_i_rdidx,
    output disp_i_ready,
    input  lsu_wbck_i_valid, lsu_wbck_i_wdat,
    output lsu_wbck_i_ready,
    input  mdv_wbck_i_valid, mdv_wbck_i_wdat,
    output mdv_wbck_i_ready,
    output longp_wbck_o_valid, longp_wbck_o_wdat, longp_wbck_o_rdidx,
    input  longp_wbck_o_ready,
    input  chk_rs1en, chk_rs2en, chk_rden,
    input  chk_rs1idx, chk_rs2idx, chk_rdidx,
    output dep_o, empty_o
  );

  // Surrounding pipeline side
  modport master (
    output disp_i_valid, disp_i_unit, disp_i_rdwen, disp_i_rdidx,
    input  disp_i_ready,
    output lsu_wbck_i_valid, lsu_wbck_i_wdat,
    input  lsu_wbck_i_ready,
    output mdv_wbck_i_valid, mdv_wbck_i_wdat,
    input  mdv_wbck_i_ready,
    input  longp_wbck_o_valid, longp_wbck_o_wdat, longp_wbck_o_rdidx,
    output longp_wbck_o_ready,
    output chk_rs1en, chk_rs2en, chk_rden,
    output chk_rs1idx, chk_rs2idx, chk_rdidx,
    input  dep_o, empty_o
  );
endinterface
`default_nettype wire

// File: rtl/e203_exu_wbck_sched.sv
`default_nettype none
// ============================================================================
// Module   : e203_exu_wbck_sched
// Brief    : In-order scheduler for long-pipeline writebacks. Tracks every
//            dispatched LSU/MULDIV instruction in a circular buffer and only
//            accepts the result of the unit that owns the oldest entry, so
//            register-file writes retire in program order. Also provides a
//            RAW check against all outstanding destination registers.
// Options  : E203_WBCK_SCHED_STALL_CNT_EN adds stall_cnt_o, a saturating
//            count of cycles where a writeback waits on the arbiter.
// Revision : 1.0 - initial release
// ============================================================================
module e203_exu_wbck_sched #(
  parameter int DEPTH   = 4,
  parameter int XLEN    = 32,
  parameter int RFIDX_W = 5
) (
  input  wire logic             clk,
  input  wire logic             rst_n,
  e203_exu_wbck_sched_if.slave  sched_if
`ifdef E203_WBCK_SCHED_STALL_CNT_EN
  ,
  output logic [31:0]           stall_cnt_o
`endif
);

  localparam int               c_IDX_W   = $clog2(DEPTH);
  localparam logic [c_IDX_W:0] c_PTR_ONE = {{c_IDX_W{1'b0}}, 1'b1};

  // Pointers carry one extra wrap bit to tell full from empty
  logic [c_IDX_W:0]   r_wr_ptr;
  logic [c_IDX_W:0]   r_rd_ptr;

  // Per-entry tracking state
  logic [DEPTH-1:0]   r_vld;
  logic [DEPTH-1:0]   r_unit;
  logic [DEPTH-1:0]   r_rdwen;
  logic [RFIDX_W-1:0] r_rdidx [DEPTH];

  logic [c_IDX_W-1:0] w_wr_idx;
  logic [c_IDX_W-1:0] w_rd_idx;
  logic               w_empty;
  logic               w_full;
  logic               w_push;
  logic               w_pop;

  logic               w_head_unit;
  logic               w_head_rdwen;
  logic [RFIDX_W-1:0] w_head_rdidx;
  logic               w_sel_valid;
  logic [XLEN-1:0]    w_sel_wdat;
  logic               w_src_ready;

  logic [DEPTH-1:0]   w_vld_set;
  logic [DEPTH-1:0]   w_vld_clr;
  logic [DEPTH-1:0]   w_dep_vec;

  assign w_wr_idx = r_wr_ptr[c_IDX_W-1:0];
  assign w_rd_idx = r_rd_ptr[c_IDX_W-1:0];
  assign w_empty  = (r_wr_ptr == r_rd_ptr);
  assign w_full   = (w_wr_idx == w_rd_idx) &&
                    (r_wr_ptr[c_IDX_W] != r_rd_ptr[c_IDX_W]);

  // A pop in the same cycle does not make room: ready depends on full only
  assign w_push = sched_if.disp_i_valid && !w_full;

  // Head entry and its owning result source
  assign w_head_unit  = r_unit[w_rd_idx];
  assign w_head_rdwen = r_rdwen[w_rd_idx];
  assign w_head_rdidx = r_rdidx[w_rd_idx];
  assign w_sel_valid  = w_head_unit ? sched_if.mdv_wbck_i_valid
                                    : sched_if.lsu_wbck_i_valid;
  assign w_sel_wdat   = w_head_unit ? sched_if.mdv_wbck_i_wdat
                                    : sched_if.lsu_wbck_i_wdat;

  // A head without rd write is retired without involving the arbiter
  assign w_src_ready = !w_empty && (w_head_rdwen ? sched_if.longp_wbck_o_ready
                                                 : 1'b1);
  assign w_pop       = w_src_ready && w_sel_valid;

  assign sched_if.disp_i_ready       = !w_full;
  assign sched_if.lsu_wbck_i_ready   = w_src_ready && !w_head_unit;
  assign sched_if.mdv_wbck_i_ready   = w_src_ready &&  w_head_unit;
  assign sched_if.longp_wbck_o_valid = !w_empty && w_head_rdwen && w_sel_valid;
  assign sched_if.longp_wbck_o_wdat  = w_sel_wdat;
  assign sched_if.longp_wbck_o_rdidx = w_head_rdidx;
  assign sched_if.empty_o            = w_empty;

  // Push and pop never target the same slot: that needs full (push refused)
  // or empty (nothing to pop)
  assign w_vld_set = w_push ? (DEPTH'(1) << w_wr_idx) : '0;
  assign w_vld_clr = w_pop  ? (DEPTH'(1) << w_rd_idx) : '0;

  // Advance the write and read pointers on push and pop
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
      end
    end
  end

  // Track which entries are outstanding; reset discards everything at once
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld <= '0;
    end else begin
      r_vld <= (r_vld & ~w_vld_clr) | w_vld_set;
    end
  end

  // Capture the entry payload on push; only meaningful while valid
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_unit[w_wr_idx]  <= sched_if.disp_i_unit;
      r_rdwen[w_wr_idx] <= sched_if.disp_i_rdwen;
      r_rdidx[w_wr_idx] <= sched_if.disp_i_rdidx;
    end
  end

  // Per-entry RAW match against every enabled check operand (x0 included)
  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_dep
      assign w_dep_vec[gi] = r_vld[gi] && r_rdwen[gi] && (
          (sched_if.chk_rs1en && (sched_if.chk_rs1idx == r_rdidx[gi])) ||
          (sched_if.chk_rs2en && (sched_if.chk_rs2idx == r_rdidx[gi])) ||
          (sched_if.chk_rden  && (sched_if.chk_rdidx  == r_rdidx[gi])));
    end
  endgenerate

  assign sched_if.dep_o = |w_dep_vec;

`ifdef E203_WBCK_SCHED_STALL_CNT_EN
  logic [31:0] r_stall_cnt;
  logic        w_stall;

  assign w_stall     = sched_if.longp_wbck_o_valid && !sched_if.longp_wbck_o_ready;
  assign stall_cnt_o = r_stall_cnt;

  // Count arbiter back-pressure cycles, saturating at all ones
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_e203_exu_wbck_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_e203_exu_wbck_sched
// Brief    : Directed bench for the in-order writeback scheduler. Expected
//            writebacks are queued at stimulus time and compared by a monitor
//            whenever a writeback handshake occurs.
// Revision : 1.0 - initial release
// ============================================================================
module tb_e203_exu_wbck_sched;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] d;
  } exp_t;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_err;
  exp_t exp_q[$];

  e203_exu_wbck_sched_if #(.XLEN(32), .RFIDX_W(5)) bus ();

`ifdef E203_WBCK_SCHED_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  e203_exu_wbck_sched #(.DEPTH(4), .XLEN(32), .RFIDX_W(5)) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sched_if (bus)
`ifdef E203_WBCK_SCHED_STALL_CNT_EN
    ,
    .stall_cnt_o (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic expect_wb(input logic [4:0] rd, input logic [31:0] d);
    exp_t e;
    e.rd = rd;
    e.d  = d;
    exp_q.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic dispatch(input logic unit, input logic rdwen, input logic [4:0] rd);
    bus.disp_i_unit  = unit;
    bus.disp_i_rdwen = rdwen;
    bus.disp_i_rdidx = rd;
    bus.disp_i_valid = 1'b1;
    step();
    bus.disp_i_valid = 1'b0;
  endtask

  // Monitor: every writeback handshake must match the oldest expected entry
  always @(negedge clk) begin
    if (rst_n && bus.longp_wbck_o_valid && bus.longp_wbck_o_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL wb_unexpected: got rd=%0d data=0x%0h expected no writeback",
                 bus.longp_wbck_o_rdidx, bus.longp_wbck_o_wdat);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("wb_rdidx", 32'(bus.longp_wbck_o_rdidx), 32'(e.rd));
        check("wb_wdat", bus.longp_wbck_o_wdat, e.d);
      end
    end
  end

  // Watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_checks = 0;
    n_err    = 0;
    rst_n    = 1'b0;
    bus.disp_i_valid       = 1'b0;
    bus.disp_i_unit        = 1'b0;
    bus.disp_i_rdwen       = 1'b0;
    bus.disp_i_rdidx       = '0;
    bus.lsu_wbck_i_valid   = 1'b0;
    bus.lsu_wbck_i_wdat    = '0;
    bus.mdv_wbck_i_valid   = 1'b0;
    bus.mdv_wbck_i_wdat    = '0;
    bus.longp_wbck_o_ready = 1'b1;
    bus.chk_rs1en  = 1'b0;
    bus.chk_rs2en  = 1'b0;
    bus.chk_rden   = 1'b0;
    bus.chk_rs1idx = '0;
    bus.chk_rs2idx = '0;
    bus.chk_rdidx  = '0;

    // Reset state
    #2;
    check("rst_disp_ready", 32'(bus.disp_i_ready), 1);
    check("rst_empty", 32'(bus.empty_o), 1);
    check("rst_dep", 32'(bus.dep_o), 0);
    check("rst_longp_valid", 32'(bus.longp_wbck_o_valid), 0);
    check("rst_lsu_ready", 32'(bus.lsu_wbck_i_ready), 0);
    check("rst_mdv_ready", 32'(bus.mdv_wbck_i_ready), 0);
    step();
    rst_n = 1'b1;
    step();

    // Ordering: MULDIV result waits behind the older LSU entry
    dispatch(1'b0, 1'b1, 5'd5);
    dispatch(1'b1, 1'b1, 5'd6);
    expect_wb(5'd5, 32'h11);
    expect_wb(5'd6, 32'h22);
    bus.mdv_wbck_i_valid = 1'b1;
    bus.mdv_wbck_i_wdat  = 32'h22;
    #1;
    check("ord_mdv_stalled0", 32'(bus.mdv_wbck_i_ready), 0);
    check("ord_longp_idle", 32'(bus.longp_wbck_o_valid), 0);
    step();
    check("ord_mdv_stalled1", 32'(bus.mdv_wbck_i_ready), 0);
    step();
    bus.lsu_wbck_i_valid = 1'b1;
    bus.lsu_wbck_i_wdat  = 32'h11;
    #1;
    check("ord_lsu_ready", 32'(bus.lsu_wbck_i_ready), 1);
    check("ord_mdv_stalled2", 32'(bus.mdv_wbck_i_ready), 0);
    check("ord_longp_valid", 32'(bus.longp_wbck_o_valid), 1);
    step();
    bus.lsu_wbck_i_valid = 1'b0;
    #1;
    check("ord_mdv_ready", 32'(bus.mdv_wbck_i_ready), 1);
    step();
    bus.mdv_wbck_i_valid = 1'b0;
    #1;
    check("ord_empty", 32'(bus.empty_o), 1);

    // Full buffer; a same-cycle pop does not admit the push
    for (int i = 1; i <= 4; i++) dispatch(1'b0, 1'b1, 5'(i));
    #1;
    check("full_disp_ready", 32'(bus.disp_i_ready), 0);
    check("full_not_empty", 32'(bus.empty_o), 0);
    bus.lsu_wbck_i_valid = 1'b1;
    bus.lsu_wbck_i_wdat  = 32'hA1;
    bus.disp_i_valid     = 1'b1;
    bus.disp_i_rdidx     = 5'd9;
    expect_wb(5'd1, 32'hA1);
    #1;
    check("full_push_pop_ready", 32'(bus.disp_i_ready), 0);
    step();
    bus.disp_i_valid    = 1'b0;
    bus.lsu_wbck_i_wdat = 32'hA2;
    expect_wb(5'd2, 32'hA2);
    #1;
    check("occ3_disp_ready", 32'(bus.disp_i_ready), 1);
    step();
    bus.lsu_wbck_i_wdat = 32'hA3;
    expect_wb(5'd3, 32'hA3);
    step();
    bus.lsu_wbck_i_wdat = 32'hA4;
    expect_wb(5'd4, 32'hA4);
    step();
    bus.lsu_wbck_i_valid = 1'b0;
    #1;
    check("occ3_drained_empty", 32'(bus.empty_o), 1);

    // Head without rd write retires with the arbiter stalled
    dispatch(1'b1, 1'b0, 5'd8);
    bus.longp_wbck_o_ready = 1'b0;
    bus.mdv_wbck_i_valid   = 1'b1;
    bus.mdv_wbck_i_wdat    = 32'h33;
    #1;
    check("nowr_mdv_ready", 32'(bus.mdv_wbck_i_ready), 1);
    check("nowr_longp_valid", 32'(bus.longp_wbck_o_valid), 0);
    step();
    bus.mdv_wbck_i_valid   = 1'b0;
    bus.longp_wbck_o_ready = 1'b1;
    #1;
    check("nowr_popped", 32'(bus.empty_o), 1);

    // RAW dependency check
    dispatch(1'b0, 1'b1, 5'd7);
    bus.chk_rs2en  = 1'b1;
    bus.chk_rs2idx = 5'd7;
    #1;
    check("dep_rs2_hit", 32'(bus.dep_o), 1);
    bus.chk_rs2en = 1'b0;
    #1;
    check("dep_rs2_disabled", 32'(bus.dep_o), 0);
    bus.chk_rs1en  = 1'b1;
    bus.chk_rs1idx = 5'd3;
    #1;
    check("dep_rs1_miss", 32'(bus.dep_o), 0);
    bus.chk_rs1en = 1'b0;
    bus.lsu_wbck_i_valid = 1'b1;
    bus.lsu_wbck_i_wdat  = 32'h77;
    expect_wb(5'd7, 32'h77);
    step();
    bus.lsu_wbck_i_valid = 1'b0;
    bus.chk_rs2en = 1'b1;
    #1;
    check("dep_after_pop", 32'(bus.dep_o), 0);
    bus.chk_rs2en = 1'b0;
    dispatch(1'b1, 1'b1, 5'd0);
    bus.chk_rden  = 1'b1;
    bus.chk_rdidx = 5'd0;
    #1;
    check("dep_x0_hit", 32'(bus.dep_o), 1);
    bus.chk_rden = 1'b0;
    bus.mdv_wbck_i_valid = 1'b1;
    bus.mdv_wbck_i_wdat  = 32'h55;
    expect_wb(5'd0, 32'h55);
    step();
    bus.mdv_wbck_i_valid = 1'b0;

    // Pointer wrap: ten simultaneous push/pop pairs, units alternating
    dispatch(1'b0, 1'b1, 5'd10);
    for (int i = 0; i < 10; i++) begin
      bus.disp_i_valid = 1'b1;
      bus.disp_i_unit  = 1'((i + 1) % 2);
      bus.disp_i_rdwen = 1'b1;
      bus.disp_i_rdidx = 5'(11 + i);
      bus.lsu_wbck_i_valid = ((i % 2) == 0);
      bus.mdv_wbck_i_valid = ((i % 2) == 1);
      bus.lsu_wbck_i_wdat  = 32'(32'h100 + i);
      bus.mdv_wbck_i_wdat  = 32'(32'h100 + i);
      expect_wb(5'(10 + i), 32'(32'h100 + i));
      #1;
      check("wrap_disp_ready", 32'(bus.disp_i_ready), 1);
      check("wrap_not_empty", 32'(bus.empty_o), 0);
      step();
    end
    bus.disp_i_valid     = 1'b0;
    bus.lsu_wbck_i_valid = 1'b1;
    bus.mdv_wbck_i_valid = 1'b0;
    bus.lsu_wbck_i_wdat  = 32'h10A;
    expect_wb(5'd20, 32'h10A);
    step();
    bus.lsu_wbck_i_valid = 1'b0;
    #1;
    check("wrap_final_empty", 32'(bus.empty_o), 1);

    // Reset with entries outstanding and a result held on the LSU port
    for (int i = 1; i <= 3; i++) dispatch(1'b0, 1'b1, 5'(i));
    bus.longp_wbck_o_ready = 1'b0;
    bus.lsu_wbck_i_valid   = 1'b1;
    bus.lsu_wbck_i_wdat    = 32'hBB;
    #1;
    check("prerst_longp_valid", 32'(bus.longp_wbck_o_valid), 1);
    check("prerst_lsu_ready", 32'(bus.lsu_wbck_i_ready), 0);
    rst_n = 1'b0;
    bus.chk_rden  = 1'b1;
    bus.chk_rdidx = 5'd1;
    #1;
    check("midrst_empty", 32'(bus.empty_o), 1);
    check("midrst_disp_ready", 32'(bus.disp_i_ready), 1);
    check("midrst_longp_valid", 32'(bus.longp_wbck_o_valid), 0);
    check("midrst_lsu_ready", 32'(bus.lsu_wbck_i_ready), 0);
    check("midrst_dep", 32'(bus.dep_o), 0);
    bus.chk_rden = 1'b0;
    bus.longp_wbck_o_ready = 1'b1;
    step();
    rst_n = 1'b1;
    #1;
    check("postrst_lsu_ready0", 32'(bus.lsu_wbck_i_ready), 0);
    step();
    check("postrst_lsu_ready1", 32'(bus.lsu_wbck_i_ready), 0);
    check("postrst_empty", 32'(bus.empty_o), 1);
    bus.lsu_wbck_i_valid = 1'b0;
    step();
    step();

    check("exp_queue_drained", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
